// File: rtl/float_accum_sequencer_if.sv
// Bundles the operand stream, command/status and adder req/ack signals of the sequencer.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface float_accum_sequencer_if #(
  parameter int float_width = 32,
  parameter int CNT_W       = 8
);
  logic                   start;
  logic [CNT_W-1:0]       count;
  logic                   in_valid;
  logic                   in_ready;
  logic [float_width-1:0] in_data;
  logic                   add_req;
  logic [float_width-1:0] add_a;
  logic [float_width-1:0] add_b;
  logic                   add_ack;
  logic [float_width-1:0] add_out;
  logic                   busy;
  logic                   done;
  logic [float_width-1:0] result;
  logic                   err;

  modport master (
    input  start, count, in_valid, in_data, add_ack, add_out,
    output in_ready, add_req, add_a, add_b, busy, done, result, err
  );

  modport slave (
    output start, count, in_valid, in_data, add_ack, add_out,
    input  in_ready, add_req, add_a, add_b, busy, done, result, err
  );
endinterface

// File: rtl/float_accum_sequencer.sv
// Sums a stream of floats by issuing one acc+operand request at a time to an
// external float adder, then presents the total with a single-cycle done pulse.
module float_accum_sequencer #(
  parameter int float_width = 32,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    rst,
  float_accum_sequencer_if.master bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, WAIT_ACK, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [float_width-1:0] acc;
  logic [float_width-1:0] add_a_q;
  logic [float_width-1:0] add_b_q;
  logic [float_width-1:0] result_q;
  logic [CNT_W-1:0]       remaining;
  logic [TW-1:0]          tcnt;
  logic                   err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.start) state_next = (bus.count == '0) ? DONE : WAIT_IN;
      WAIT_IN:  if (bus.in_valid) state_next = ISSUE;
      ISSUE:    state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.add_ack)      state_next = (remaining == CNT_W'(1)) ? DONE : WAIT_IN;
        else if (tcnt == TMAX) state_next = IDLE;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // result is loaded on the edge that enters DONE so it is valid alongside done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      result_q  <= '0;
      remaining <= '0;
      tcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            remaining <= bus.count;
            acc       <= '0;
            err_q     <= 1'b0;
            if (bus.count == '0) result_q <= '0;
          end
        end
        WAIT_IN: begin
          if (bus.in_valid) begin
            add_b_q <= bus.in_data;
            add_a_q <= acc;
            tcnt    <= '0;
          end
        end
        WAIT_ACK: begin
          if (bus.add_ack) begin
            acc       <= bus.add_out;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) result_q <= bus.add_out;
          end else if (tcnt == TMAX) begin
            err_q <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (state == WAIT_IN);
  assign bus.add_req  = (state == ISSUE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.add_a    = add_a_q;
  assign bus.add_b    = add_b_q;
  assign bus.result   = result_q;
  assign bus.err      = err_q;
endmodule
